// File: rtl/scale_coef_gen.sv
// Bilinear scaler coordinate/coefficient generator: walks the destination raster and emits the
// top-left source pixel plus dx/dy/dxy weights per beat over a 2-stage valid/ready pipeline.
//
// state  | meaning
// S_IDLE | waiting for start; pipeline may still be draining
// S_RUN  | issuing one beat per enabled cycle in raster order
module scale_coef_gen #(
   parameter int SRC_W  = 1280,
   parameter int SRC_H  = 720,
   parameter int DST_W  = 960,
   parameter int DST_H  = 540,
   parameter int FRAC_W = 5,
   parameter int GUARD  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      clr,
   input  logic                      cont,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [$clog2(SRC_W)-1:0]  out_x,
   output logic [$clog2(SRC_H)-1:0]  out_y,
   output logic [FRAC_W-1:0]         out_dx,
   output logic [FRAC_W-1:0]         out_dy,
   output logic [2*FRAC_W-1:0]       out_dxy,
   output logic                      out_sof,
   output logic                      out_eol,
   output logic                      out_eof,
   output logic                      busy
);

   localparam int XW      = $clog2(SRC_W);
   localparam int YW      = $clog2(SRC_H);
   localparam int FB      = FRAC_W + GUARD;
   localparam int SRC_MAX = (SRC_W > SRC_H) ? SRC_W : SRC_H;
   localparam int AW      = $clog2(SRC_MAX) + FB + 1;
   localparam int IW      = AW - FB;
   localparam int PW      = (DST_W > 1) ? $clog2(DST_W) : 1;
   localparam int LW      = (DST_H > 1) ? $clog2(DST_H) : 1;

   // Negative start phase (upscale) is clamped so the first sample sits on source pixel 0.
   localparam longint STEP_X_L = (longint'(SRC_W) << FB) / longint'(DST_W);
   localparam longint STEP_Y_L = (longint'(SRC_H) << FB) / longint'(DST_H);
   localparam longint INIT_X_R = (STEP_X_L >>> 1) - (longint'(1) << (FB - 1));
   localparam longint INIT_Y_R = (STEP_Y_L >>> 1) - (longint'(1) << (FB - 1));
   localparam logic [AW-1:0] STEP_X = AW'(STEP_X_L);
   localparam logic [AW-1:0] STEP_Y = AW'(STEP_Y_L);
   localparam logic [AW-1:0] INIT_X = (INIT_X_R < 0) ? '0 : AW'(INIT_X_R);
   localparam logic [AW-1:0] INIT_Y = (INIT_Y_R < 0) ? '0 : AW'(INIT_Y_R);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       px_q, px_d;
   logic [LW-1:0]       ln_q, ln_d;
   logic [AW-1:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;

   logic                s1_valid_q, s1_valid_d;
   logic [XW-1:0]       s1_x_q, s1_x_d;
   logic [YW-1:0]       s1_y_q, s1_y_d;
   logic [FRAC_W-1:0]   s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
   logic                s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;

   logic                out_valid_q, out_valid_d;
   logic [XW-1:0]       out_x_q, out_x_d;
   logic [YW-1:0]       out_y_q, out_y_d;
   logic [FRAC_W-1:0]   out_dx_q, out_dx_d, out_dy_q, out_dy_d;
   logic [2*FRAC_W-1:0] out_dxy_q, out_dxy_d;
   logic                out_sof_q, out_sof_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;

   logic                en, issue, last_px, last_ln;
   logic [IW-1:0]       raw_x, raw_y;
   logic [XW-1:0]       map_x;
   logic [YW-1:0]       map_y;
   logic [FRAC_W-1:0]   map_dx, map_dy;

   assign busy = (state_q == S_RUN) | s1_valid_q | out_valid_q;

   always_comb begin
      state_d     = state_q;
      px_d        = px_q;
      ln_d        = ln_q;
      acc_x_d     = acc_x_q;
      acc_y_d     = acc_y_q;
      s1_valid_d  = s1_valid_q;
      s1_x_d      = s1_x_q;
      s1_y_d      = s1_y_q;
      s1_dx_d     = s1_dx_q;
      s1_dy_d     = s1_dy_q;
      s1_sof_d    = s1_sof_q;
      s1_eol_d    = s1_eol_q;
      s1_eof_d    = s1_eof_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_dx_d    = out_dx_q;
      out_dy_d    = out_dy_q;
      out_dxy_d   = out_dxy_q;
      out_sof_d   = out_sof_q;
      out_eol_d   = out_eol_q;
      out_eof_d   = out_eof_q;

      en      = !out_valid_q | out_ready;
      issue   = (state_q == S_RUN) & en;
      last_px = (px_q == PW'(DST_W - 1));
      last_ln = (ln_q == LW'(DST_H - 1));

      raw_x = acc_x_q[AW-1:FB];
      raw_y = acc_y_q[AW-1:FB];
      if (raw_x > IW'(SRC_W - 2)) begin
         map_x  = XW'(SRC_W - 2);
         map_dx = '1;
      end else begin
         map_x  = raw_x[XW-1:0];
         map_dx = acc_x_q[FB-1:GUARD];
      end
      if (raw_y > IW'(SRC_H - 2)) begin
         map_y  = YW'(SRC_H - 2);
         map_dy = '1;
      end else begin
         map_y  = raw_y[YW-1:0];
         map_dy = acc_y_q[FB-1:GUARD];
      end

      if (en) begin
         s1_valid_d  = issue;
         s1_x_d      = map_x;
         s1_y_d      = map_y;
         s1_dx_d     = map_dx;
         s1_dy_d     = map_dy;
         s1_sof_d    = (px_q == '0) & (ln_q == '0);
         s1_eol_d    = last_px;
         s1_eof_d    = last_px & last_ln;
         out_valid_d = s1_valid_q;
         out_x_d     = s1_x_q;
         out_y_d     = s1_y_q;
         out_dx_d    = s1_dx_q;
         out_dy_d    = s1_dy_q;
         out_dxy_d   = {{FRAC_W{1'b0}}, s1_dx_q} * {{FRAC_W{1'b0}}, s1_dy_q};
         out_sof_d   = s1_sof_q;
         out_eol_d   = s1_eol_q;
         out_eof_d   = s1_eof_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start && !busy) begin
               state_d = S_RUN;
               px_d    = '0;
               ln_d    = '0;
               acc_x_d = INIT_X;
               acc_y_d = INIT_Y;
            end
         end
         S_RUN: begin
            if (en) begin
               if (last_px) begin
                  px_d    = '0;
                  acc_x_d = INIT_X;
                  if (last_ln) begin
                     ln_d    = '0;
                     acc_y_d = INIT_Y;
                     if (!cont) state_d = S_IDLE;
                  end else begin
                     ln_d    = ln_q + LW'(1);
                     acc_y_d = acc_y_q + STEP_Y;
                  end
               end else begin
                  px_d    = px_q + PW'(1);
                  acc_x_d = acc_x_q + STEP_X;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything, including a coincident start.
      if (clr) begin
         state_d     = S_IDLE;
         px_d        = '0;
         ln_d        = '0;
         acc_x_d     = '0;
         acc_y_d     = '0;
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         out_sof_d   = 1'b0;
         out_eol_d   = 1'b0;
         out_eof_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         px_q        <= '0;
         ln_q        <= '0;
         acc_x_q     <= '0;
         acc_y_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_x_q      <= '0;
         s1_y_q      <= '0;
         s1_dx_q     <= '0;
         s1_dy_q     <= '0;
         s1_sof_q    <= 1'b0;
         s1_eol_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_dx_q    <= '0;
         out_dy_q    <= '0;
         out_dxy_q   <= '0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         px_q        <= px_d;
         ln_q        <= ln_d;
         acc_x_q     <= acc_x_d;
         acc_y_q     <= acc_y_d;
         s1_valid_q  <= s1_valid_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s1_dx_q     <= s1_dx_d;
         s1_dy_q     <= s1_dy_d;
         s1_sof_q    <= s1_sof_d;
         s1_eol_q    <= s1_eol_d;
         s1_eof_q    <= s1_eof_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_dx_q    <= out_dx_d;
         out_dy_q    <= out_dy_d;
         out_dxy_q   <= out_dxy_d;
         out_sof_q   <= out_sof_d;
         out_eol_q   <= out_eol_d;
         out_eof_q   <= out_eof_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_dx    = out_dx_q;
   assign out_dy    = out_dy_q;
   assign out_dxy   = out_dxy_q;
   assign out_sof   = out_sof_q;
   assign out_eol   = out_eol_q;
   assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_scale_coef_gen.sv
// Directed bench for scale_coef_gen: a default 1280x720->960x540 instance and a 4x4->8x8 upscale
// instance share clock and reset.
module tb_scale_coef_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic        a_start = 0, a_clr = 0, a_cont = 0, a_ready = 0;
   logic        a_valid, a_sof, a_eol, a_eof, a_busy;
   logic [10:0] a_x;
   logic [9:0]  a_y;
   logic [4:0]  a_dx, a_dy;
   logic [9:0]  a_dxy;

   logic        b_start = 0, b_clr = 0, b_cont = 0, b_ready = 0;
   logic        b_valid, b_sof, b_eol, b_eof, b_busy;
   logic [1:0]  b_x, b_y;
   logic [4:0]  b_dx, b_dy;
   logic [9:0]  b_dxy;

   scale_coef_gen u_def (
      .clk(clk), .rst_n(rst_n), .start(a_start), .clr(a_clr), .cont(a_cont),
      .out_ready(a_ready), .out_valid(a_valid), .out_x(a_x), .out_y(a_y),
      .out_dx(a_dx), .out_dy(a_dy), .out_dxy(a_dxy), .out_sof(a_sof),
      .out_eol(a_eol), .out_eof(a_eof), .busy(a_busy)
   );

   scale_coef_gen #(.SRC_W(4), .SRC_H(4), .DST_W(8), .DST_H(8), .FRAC_W(5), .GUARD(8)) u_up (
      .clk(clk), .rst_n(rst_n), .start(b_start), .clr(b_clr), .cont(b_cont),
      .out_ready(b_ready), .out_valid(b_valid), .out_x(b_x), .out_y(b_y),
      .out_dx(b_dx), .out_dy(b_dy), .out_dxy(b_dxy), .out_sof(b_sof),
      .out_eol(b_eol), .out_eof(b_eof), .busy(b_busy)
   );

   // Upscale row/column pattern: positions 0..7 map to source 0,0,1,1,2,2 then clamp.
   int ut_x[8] = '{0, 0, 1, 1, 2, 2, 2, 2};
   int ut_d[8] = '{0, 16, 0, 16, 0, 16, 31, 31};

   // Default-instance line 0 beats 0..7.
   int dt_x[8] = '{0, 1, 2, 4, 5, 6, 8, 9};
   int dt_d[8] = '{5, 15, 26, 5, 15, 26, 5, 15};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [26:0] exp_b(int i);
      int px, ln;
      logic [1:0] x, y;
      logic [4:0] dx, dy;
      logic [9:0] dxy;
      px  = i % 8;
      ln  = (i / 8) % 8;
      x   = 2'(ut_x[px]);
      y   = 2'(ut_x[ln]);
      dx  = 5'(ut_d[px]);
      dy  = 5'(ut_d[ln]);
      dxy = {5'b0, dx} * {5'b0, dy};
      return {x, dx, y, dy, dxy, (i % 64 == 0), (px == 7), (i % 64 == 63)};
   endfunction

   task automatic test_reset();
      #1;
      total_cnt++;
      if ({a_valid, a_x, a_y, a_dx, a_dy, a_dxy, a_sof, a_eol, a_eof, a_busy} !== '0)
         $display("FAIL reset_def: got valid=%b x=%0d y=%0d busy=%b, expected all zero",
                  a_valid, a_x, a_y, a_busy);
      else pass_cnt++;
      total_cnt++;
      if ({b_valid, b_x, b_y, b_dx, b_dy, b_dxy, b_sof, b_eol, b_eof, b_busy} !== '0)
         $display("FAIL reset_up: got valid=%b x=%0d y=%0d busy=%b, expected all zero",
                  b_valid, b_x, b_y, b_busy);
      else pass_cnt++;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_first_beats();
      int eolc = 0;
      a_ready = 1;
      a_start = 1;
      step();
      a_start = 0;
      total_cnt++;
      if (a_valid !== 1'b0) $display("FAIL lat0: out_valid=%b expected 0", a_valid);
      else pass_cnt++;
      step();
      total_cnt++;
      if (a_valid !== 1'b0) $display("FAIL lat1: out_valid=%b expected 0", a_valid);
      else pass_cnt++;
      step();
      total_cnt++;
      if (a_valid !== 1'b1) $display("FAIL lat2: out_valid=%b expected 1", a_valid);
      else pass_cnt++;
      for (int k = 0; k < 8; k++) begin
         total_cnt++;
         if (a_valid !== 1'b1 || a_x !== 11'(dt_x[k]) || a_dx !== 5'(dt_d[k]) || a_y !== 10'd0 ||
             a_dy !== 5'd5 || a_dxy !== 10'(dt_d[k] * 5) || a_sof !== (k == 0))
            $display("FAIL first_beat%0d: got v=%b x=%0d dx=%0d y=%0d dy=%0d dxy=%0d sof=%b expected x=%0d dx=%0d y=0 dy=5 dxy=%0d sof=%0d",
                     k, a_valid, a_x, a_dx, a_y, a_dy, a_dxy, a_sof, dt_x[k], dt_d[k], dt_d[k] * 5, k == 0);
         else pass_cnt++;
         step();
      end
      for (int k = 8; k < 1000; k++) begin
         if (a_eol === 1'b1) eolc++;
         step();
      end
      total_cnt++;
      if (eolc != 1) $display("FAIL eol_count: got %0d eol beats in 8..999, expected 1", eolc);
      else pass_cnt++;
      total_cnt++;
      if (a_valid !== 1'b1 || a_x !== 11'd53 || a_dx !== 5'd15 || a_y !== 10'd1 || a_dy !== 5'd15 ||
          a_dxy !== 10'd225)
         $display("FAIL beat1000: got v=%b x=%0d dx=%0d y=%0d dy=%0d dxy=%0d expected x=53 dx=15 y=1 dy=15 dxy=225",
                  a_valid, a_x, a_dx, a_y, a_dy, a_dxy);
      else pass_cnt++;
   endtask

   task automatic test_clr();
      a_clr = 1;
      step();
      a_clr = 0;
      total_cnt++;
      if (a_valid !== 1'b0 || a_busy !== 1'b0)
         $display("FAIL clr_abort: got valid=%b busy=%b expected 0 0", a_valid, a_busy);
      else pass_cnt++;
      a_clr = 1;
      a_start = 1;
      step();
      a_clr = 0;
      a_start = 0;
      step();
      step();
      total_cnt++;
      if (a_valid !== 1'b0 || a_busy !== 1'b0)
         $display("FAIL clr_start_drop: got valid=%b busy=%b expected 0 0", a_valid, a_busy);
      else pass_cnt++;
      a_start = 1;
      step();
      a_start = 0;
      step();
      step();
      total_cnt++;
      if (a_valid !== 1'b1 || a_sof !== 1'b1 || a_x !== 11'd0 || a_y !== 10'd0 || a_dx !== 5'd5 ||
          a_dy !== 5'd5)
         $display("FAIL clr_restart: got v=%b sof=%b x=%0d y=%0d dx=%0d dy=%0d expected 1 1 0 0 5 5",
                  a_valid, a_sof, a_x, a_y, a_dx, a_dy);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      int got = 0;
      logic held;
      logic [10:0] hx;
      logic [4:0] hdx;
      logic hsof;
      a_clr = 1;
      step();
      a_clr = 0;
      a_start = 1;
      step();
      a_start = 0;
      for (int c = 0; c < 200 && got < 8; c++) begin
         a_ready = 1'($urandom_range(0, 1));
         held = a_valid & ~a_ready;
         hx = a_x;
         hdx = a_dx;
         hsof = a_sof;
         if (a_valid === 1'b1 && a_ready === 1'b1) begin
            total_cnt++;
            if (a_x !== 11'(dt_x[got]) || a_dx !== 5'(dt_d[got]) || a_dy !== 5'd5 ||
                a_sof !== (got == 0))
               $display("FAIL stall_beat%0d: got x=%0d dx=%0d dy=%0d sof=%b expected x=%0d dx=%0d dy=5 sof=%0d",
                        got, a_x, a_dx, a_dy, a_sof, dt_x[got], dt_d[got], got == 0);
            else pass_cnt++;
            got++;
         end
         step();
         if (held) begin
            total_cnt++;
            if (a_valid !== 1'b1 || a_x !== hx || a_dx !== hdx || a_sof !== hsof)
               $display("FAIL stall_hold: got v=%b x=%0d dx=%0d sof=%b expected 1 %0d %0d %b",
                        a_valid, a_x, a_dx, a_sof, hx, hdx, hsof);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (got != 8) $display("FAIL stall_timeout: got %0d beats, expected 8", got);
      else pass_cnt++;
      a_ready = 1;
   endtask

   task automatic test_upscale();
      logic [26:0] e;
      b_cont = 0;
      b_ready = 1;
      b_start = 1;
      step();
      b_start = 0;
      step();
      step();
      for (int i = 0; i < 64; i++) begin
         e = exp_b(i);
         total_cnt++;
         if (b_valid !== 1'b1 || {b_x, b_dx, b_y, b_dy, b_dxy, b_sof, b_eol, b_eof} !== e)
            $display("FAIL up_beat%0d: got v=%b x=%0d dx=%0d y=%0d dy=%0d dxy=%0d sof/eol/eof=%b%b%b expected fields %h",
                     i, b_valid, b_x, b_dx, b_y, b_dy, b_dxy, b_sof, b_eol, b_eof, e);
         else pass_cnt++;
         if (i == 63) begin
            total_cnt++;
            if (b_busy !== 1'b1) $display("FAIL up_busy_eof: busy=%b expected 1", b_busy);
            else pass_cnt++;
         end
         step();
      end
      total_cnt++;
      if (b_valid !== 1'b0 || b_busy !== 1'b0)
         $display("FAIL up_busy_drop: got valid=%b busy=%b expected 0 0", b_valid, b_busy);
      else pass_cnt++;
   endtask

   task automatic test_cont_and_reset();
      logic [26:0] e;
      b_cont = 1;
      b_ready = 1;
      b_start = 1;
      step();
      b_start = 0;
      step();
      step();
      for (int i = 0; i < 72; i++) begin
         e = exp_b(i);
         total_cnt++;
         if (b_valid !== 1'b1 || {b_x, b_dx, b_y, b_dy, b_dxy, b_sof, b_eol, b_eof} !== e)
            $display("FAIL cont_beat%0d: got v=%b x=%0d dx=%0d y=%0d dy=%0d sof/eol/eof=%b%b%b expected fields %h",
                     i, b_valid, b_x, b_dx, b_y, b_dy, b_sof, b_eol, b_eof, e);
         else pass_cnt++;
         b_start = (i == 10);
         step();
         b_start = 0;
      end
      #3;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({b_valid, b_x, b_y, b_dx, b_dy, b_dxy, b_sof, b_eol, b_eof, b_busy} !== '0)
         $display("FAIL async_reset_up: got valid=%b x=%0d y=%0d dxy=%0d busy=%b expected all zero",
                  b_valid, b_x, b_y, b_dxy, b_busy);
      else pass_cnt++;
      total_cnt++;
      if ({a_valid, a_x, a_y, a_dx, a_dy, a_dxy, a_sof, a_eol, a_eof, a_busy} !== '0)
         $display("FAIL async_reset_def: got valid=%b x=%0d busy=%b expected all zero",
                  a_valid, a_x, a_busy);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_first_beats();
      test_clr();
      test_stall();
      test_upscale();
      test_cont_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
